// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the multi-field BCD countdown timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        SET   = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALERT = 2'd3
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int FIELD_W     = 8;
    localparam int FIELD_MAX   = 59;

    // Packs a decimal value 0..99 as {tens, ones}.
    function automatic logic [FIELD_W-1:0] to_bcd(input int v);
        return {BCD_DIGIT_W'(v / 10), BCD_DIGIT_W'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_field.sv
// One two-digit BCD field: edit inc/dec wrap in place, countdown borrows via borrow_in/out.
module bcd_field
    import bcd_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_val,
    input  logic               inc,
    input  logic               dec,
    input  logic               borrow_in,
    output logic               borrow_out,
    input  logic [FIELD_W-1:0] max,
    output logic [FIELD_W-1:0] value
);

    function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] m);
        if (v == m)
            return '0;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [FIELD_W-1:0] bcd_dec(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] m);
        if (v == '0)
            return m;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign borrow_out = borrow_in && (value == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (borrow_in)
            value <= bcd_dec(value, max);
        else if (inc && !dec)
            value <= bcd_inc(value, max);
        else if (dec && !inc)
            value <= bcd_dec(value, max);
    end

endmodule

// File: rtl/multi_field_bcd_timer.sv
// Cascaded BCD countdown timer with SET/RUN/PAUSE/ALERT control.
// Define BCD_TIMER_AUTORELOAD_EN to reload the start value on expiry and keep running.
module multi_field_bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int N_FIELDS = 2,
    parameter int TICK_DIV = 100_000_000,
    parameter int TOP_MAX  = 59,
    localparam int SEL_W   = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  inc,
    input  logic                  dec,
    input  logic [SEL_W-1:0]      field_sel,
    input  logic                  clear,
    input  logic                  alert_off,
    output logic [8*N_FIELDS-1:0] bcd,
    output logic                  running,
    output logic                  alert,
    output logic                  zero
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t                  state;
    logic [PW-1:0]           presc;
    logic                    wrap, tick, expire, edit_en, load;
    logic [N_FIELDS:0]       borrow;
    logic [8*N_FIELDS-1:0]   load_src;

    assign wrap    = (presc == PW'(TICK_DIV - 1));
    assign tick    = (state == RUN) && !clear && !start_stop && wrap;
    // A top-field borrow would be an underflow; treat it as expiry as well.
    assign expire  = (tick && (bcd == (8*N_FIELDS)'(1))) || borrow[N_FIELDS];
    assign edit_en = (state == SET) && !clear && !start_stop && !alert_off;
    assign zero    = (bcd == '0);
    assign running = (state == RUN);
    assign borrow[0] = tick;

`ifdef BCD_TIMER_AUTORELOAD_EN
    logic [8*N_FIELDS-1:0] reload_val;
    assign load     = expire;
    assign load_src = reload_val;
`else
    assign load     = 1'b0;
    assign load_src = '0;
`endif

    for (genvar i = 0; i < N_FIELDS; i++) begin : g_field
        localparam logic [SEL_W-1:0]   IDX  = SEL_W'(i);
        localparam logic [FIELD_W-1:0] FMAX = (i == N_FIELDS - 1) ? to_bcd(TOP_MAX)
                                                                  : to_bcd(FIELD_MAX);
        bcd_field u_field (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .load       (load),
            .load_val   (load_src[FIELD_W*i +: FIELD_W]),
            .inc        (edit_en && inc && (field_sel == IDX)),
            .dec        (edit_en && dec && (field_sel == IDX)),
            .borrow_in  (borrow[i]),
            .borrow_out (borrow[i+1]),
            .max        (FMAX),
            .value      (bcd[FIELD_W*i +: FIELD_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SET;
            alert <= 1'b0;
            presc <= '0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_val <= '0;
`endif
        end else if (clear) begin
            state <= SET;
            alert <= 1'b0;
            presc <= '0;
        end else begin
            case (state)
                SET: begin
                    if (start_stop && !zero) begin
                        state <= RUN;
                        presc <= '0;
`ifdef BCD_TIMER_AUTORELOAD_EN
                        reload_val <= bcd;
`endif
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state <= PAUSE;
                    end else begin
                        presc <= wrap ? '0 : presc + 1'b1;
                        if (expire) begin
                            alert <= 1'b1;
`ifndef BCD_TIMER_AUTORELOAD_EN
                            state <= ALERT;
`endif
                        end else if (alert_off) begin
                            alert <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (start_stop)
                        state <= RUN;
                    else if (alert_off)
                        alert <= 1'b0;
                end
                ALERT: begin
                    if (alert_off) begin
                        alert <= 1'b0;
                        state <= SET;
                    end
                end
                default: state <= SET;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_field_bcd_timer.sv
// Directed bench for multi_field_bcd_timer with N_FIELDS=2, TICK_DIV=4.
module tb_multi_field_bcd_timer;
    import bcd_timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_stop = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic [0:0]  field_sel = 1'b0;
    logic        clear = 1'b0;
    logic        alert_off = 1'b0;
    logic [15:0] bcd;
    logic        running, alert, zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_field_bcd_timer #(
        .N_FIELDS (2),
        .TICK_DIV (4),
        .TOP_MAX  (59)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .inc        (inc),
        .dec        (dec),
        .field_sel  (field_sel),
        .clear      (clear),
        .alert_off  (alert_off),
        .bcd        (bcd),
        .running    (running),
        .alert      (alert),
        .zero       (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edit(input logic up, input logic down, input logic sel);
        inc = up; dec = down; field_sel = sel;
        cyc();
        inc = 1'b0; dec = 1'b0;
    endtask

    task automatic press_ss();
        start_stop = 1'b1; cyc(); start_stop = 1'b0;
    endtask

    task automatic press_clear();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    task automatic press_aoff();
        alert_off = 1'b1; cyc(); alert_off = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_bcd",     bcd,       16'h0000);
        check("rst_running", running,   0);
        check("rst_alert",   alert,     0);
        check("rst_zero",    zero,      1);
        check("rst_state",   dut.state, SET);
        cyc();
        reset = 1'b0;
        cyc();

        repeat (3) edit(1'b1, 1'b0, 1'b0);
        check("inc_x3",         bcd,     16'h0003);
        check("inc_x3_running", running, 0);
        repeat (2) edit(1'b1, 1'b0, 1'b1);
        check("inc_f1",         bcd,     16'h0203);
        edit(1'b1, 1'b1, 1'b0);
        check("inc_dec_both",   bcd,     16'h0203);
        press_clear();
        check("clear_set",      bcd,     16'h0000);

        edit(1'b0, 1'b1, 1'b1);
        check("top_wrap_dn",    bcd,     16'h5900);
        edit(1'b1, 1'b0, 1'b1);
        check("top_wrap_up",    bcd,     16'h0000);
        edit(1'b1, 1'b0, 1'b1);
        edit(1'b0, 1'b1, 1'b0);
        check("f0_dec_wrap",    bcd,     16'h0159);
        edit(1'b1, 1'b0, 1'b0);
        check("f0_inc_wrap",    bcd,     16'h0100);

        // 01:00 -> run
        press_ss();
        check("run_entered",    running, 1);
        cyc(3);
        check("pre_tick1",      bcd,     16'h0100);
        cyc();
        check("tick1",          bcd,     16'h0059);
        cyc(3);
        check("pre_tick2",      bcd,     16'h0059);
        cyc();
        check("tick2",          bcd,     16'h0058);

        // pause with residual prescaler count of 2
        cyc(2);
        check("presc_before",   dut.presc, 2);
        press_ss();
        check("paused",         running, 0);
        cyc(10);
        check("pause_hold_bcd", bcd,     16'h0058);
        check("pause_hold_ps",  dut.presc, 2);
        press_ss();
        check("resumed",        running, 1);
        cyc();
        check("resume_pre",     bcd,     16'h0058);
        cyc();
        check("resume_tick",    bcd,     16'h0057);

        press_clear();
        check("clr_run_bcd",    bcd,     16'h0000);
        check("clr_run_state",  dut.state, SET);
        press_ss();
        check("ss_zero_ignored", running, 0);

        // 00:02 -> expiry
        repeat (2) edit(1'b1, 1'b0, 1'b0);
        check("load_0002",      bcd,     16'h0002);
        press_ss();
        edit(1'b1, 1'b0, 1'b0);
        cyc(6);
        check("inc_in_run",     bcd,     16'h0001);
        check("no_alert_yet",   alert,   0);
        cyc();
`ifdef BCD_TIMER_AUTORELOAD_EN
        check("ar_bcd",         bcd,     16'h0002);
        check("ar_alert",       alert,   1);
        check("ar_running",     running, 1);
        press_aoff();
        check("ar_aoff_alert",  alert,   0);
        check("ar_aoff_run",    running, 1);
        press_clear();
`else
        check("exp_bcd",        bcd,     16'h0000);
        check("exp_alert",      alert,   1);
        check("exp_running",    running, 0);
        check("exp_state",      dut.state, ALERT);
        check("exp_zero",       zero,    1);
        press_aoff();
        check("aoff_alert",     alert,   0);
        check("aoff_state",     dut.state, SET);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
